xnor_conv_pe_array_kxk: RTL and testbench
=========================================

Name: xnor_conv_pe_array_kxk

Overview:
- Parametrised KxK x CH binary (XNOR-popcount) convolution window engine; successor to the fixed 3x3 XNOR PE array.
- Weights are loaded serially, one pixel per beat; image columns are then streamed in with a valid/ready handshake.
- Produces one popcount and one binarised activation per window position, with single-entry output buffering and backpressure.
- Sits between the line-buffer/column feeder and the activation/pooling stage.

Parameters:
- K, 3, kernel height and width.
- CH, 1, input channels; bits per pixel.
- PSUM_WIDTH, 4, popcount width. Must satisfy 2^PSUM_WIDTH - 1 >= K*K*CH.

Ports:
- clk  input  1  clock; rising edge.
- rst  input  1  reset, asynchronous and active-low.
- w_load_start  input  1  pulse; begins a weight load.
- w_valid  input  1  weight beat valid.
- w_in  input  CH  one weight pixel per beat.
- w_done  output  1  high while a complete weight set is held.
- col_valid  input  1  column beat valid.
- col_ready  output  1  column beat accepted when col_valid and col_ready are both high.
- col_in  input  K*CH  one image column; row r is col_in[r*CH +: CH].
- row_start  input  1  qualifies the accepted column as first of a new row.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_psum  output  PSUM_WIDTH  XNOR match count for the window.
- out_bit  output  1  binarised activation.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; weights=0; window=0; fill count=0; beat count=0; w_done=0; col_ready=0; out_valid=0; out_psum=0; out_bit=0.
- FSM states: IDLE, LOAD_W, RUN.
  - IDLE: w_load_start -> LOAD_W; beat count cleared.
  - LOAD_W: each cycle with w_valid, w_in is written to weight position j = beat count, then beat count increments. Position j = c*K + r, where c=0 is the oldest window column. On beat K*K-1 -> RUN and w_done=1. w_load_start is ignored in LOAD_W.
  - RUN: w_load_start with out_valid=0 -> LOAD_W, w_done=0, fill count=0. If out_valid=1, w_load_start is ignored.
- col_ready = (state==RUN) && (!out_valid || out_ready). It is combinational.
- On an accepted column:
  - Window shifts: col 0 is dropped, the new column enters at col K-1.
  - Fill count becomes 1 if row_start=1; otherwise fill+1, saturating at K.
- Computation: when the fill count after an accept equals K, psum = popcount of ~(window XOR weights) over K*K*CH bits. It is registered next cycle into out_psum/out_bit with out_valid=1. Latency is 1 cycle from accept.
- Accepts with fill < K (row start, first K-1 columns of a row) produce no output.
- Output holding and draining:
  - out_valid && !out_ready: out_psum and out_bit are held stable, and col_ready=0.
  - out_valid && out_ready with a simultaneous new accept reaching fill K: the output reloads and out_valid stays 1.
  - out_valid && out_ready with no new result: out_valid -> 0, out_psum/out_bit hold their last values.
- out_bit (default) = (psum >= ceil(K*K*CH/2)). For K=3, CH=1 the threshold is 5.
- Width: psum is computed at PSUM_WIDTH with no truncation, guaranteed by the parameter constraint.
- Reset mid-operation returns to IDLE; the partial weight set is discarded (w_done=0).

Optional Feature:
- Macro XNOR_CONV_THRESHOLD_EN.
- Defined: adds port thresh input PSUM_WIDTH, sampled on each result register load; out_bit = (psum >= thresh).
- Undefined: no thresh port; fixed threshold ceil(K*K*CH/2).
- All other behaviour is identical.

Test Plan (K=3, CH=1, PSUM_WIDTH=4, out_ready=1 unless stated):
- Reset: hold rst=0 -> out_valid=0, out_psum=0, out_bit=0, col_ready=0, w_done=0. Release -> col_ready stays 0 in IDLE.
- All-ones match: load 9 beats of w_in=1 -> w_done=1 after the 9th beat. Feed col_in=3'b111 x3 with row_start on the first -> one cycle after the 3rd accept, out_valid=1, out_psum=9, out_bit=1. 4th column 3'b000 -> out_psum=6, out_bit=1. 5th column 3'b000 -> out_psum=3, out_bit=0.
- Row restart: with ones weights, feed col 3'b111, then row_start with 3'b111 on the 2nd column -> no out_valid until 2 more accepts (3 columns after the restart); then out_psum=9.
- Backpressure: out_ready=0 after the first result -> col_ready=0; out_psum is held for 5 cycles; col_valid is ignored. Raise out_ready -> result consumed and next column accepted in the same cycle.
- Weight reload: in RUN with out_valid=0, pulse w_load_start and load w_in=0 x9 -> w_done toggles 0 then 1. Columns 3'b000 x3 -> out_psum=9.
- Reset mid-load: assert rst=0 after 4 weight beats -> state IDLE, w_done=0. Columns are not accepted until a fresh 9-beat load completes.
- With XNOR_CONV_THRESHOLD_EN defined, thresh=7: out_psum=6 -> out_bit=0; out_psum=7 -> out_bit=1.

Source files
------------

// File: rtl/xnor_conv_pe_array_kxk_if.sv
// Handshake bundle between the column feeder (master) and the KxK XNOR PE array (slave).
// With XNOR_CONV_THRESHOLD_EN defined the bundle also carries a runtime threshold.
interface xnor_conv_pe_array_kxk_if #(
    parameter int K          = 3,
    parameter int CH         = 1,
    parameter int PSUM_WIDTH = 4
);
    logic                  w_load_start;
    logic                  w_valid;
    logic [CH-1:0]         w_in;
    logic                  w_done;
    logic                  col_valid;
    logic                  col_ready;
    logic [K*CH-1:0]       col_in;
    logic                  row_start;
    logic                  out_valid;
    logic                  out_ready;
    logic [PSUM_WIDTH-1:0] out_psum;
    logic                  out_bit;
`ifdef XNOR_CONV_THRESHOLD_EN
    logic [PSUM_WIDTH-1:0] thresh;
`endif

    modport master (
        output w_load_start, w_valid, w_in, col_valid, col_in, row_start, out_ready,
`ifdef XNOR_CONV_THRESHOLD_EN
        output thresh,
`endif
        input  w_done, col_ready, out_valid, out_psum, out_bit
    );

    modport slave (
        input  w_load_start, w_valid, w_in, col_valid, col_in, row_start, out_ready,
`ifdef XNOR_CONV_THRESHOLD_EN
        input  thresh,
`endif
        output w_done, col_ready, out_valid, out_psum, out_bit
    );
endinterface

// File: rtl/xnor_conv_pe_array_kxk.sv
// KxK x CH XNOR-popcount window engine: serial weight load, streamed columns, 1-deep output buffer.
// Optional runtime threshold via XNOR_CONV_THRESHOLD_EN; otherwise fixed at ceil(K*K*CH/2).
module xnor_conv_pe_array_kxk #(
    parameter int K          = 3,
    parameter int CH         = 1,
    parameter int PSUM_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    xnor_conv_pe_array_kxk_if.slave  bus
);
    localparam int N  = K * K * CH;
    localparam int FW = $clog2(K + 1);
    localparam int BW = $clog2(K * K + 1);
    localparam logic [PSUM_WIDTH-1:0] THRESH_DEF = PSUM_WIDTH'((N + 1) / 2);

    typedef enum logic [1:0] {IDLE, LOAD_W, RUN} state_t;

    state_t                state_q, state_d;
    logic [N-1:0]          weights_q, weights_d;
    logic [N-1:0]          window_q, window_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  w_done_q, w_done_d;
    logic                  out_valid_q, out_valid_d;
    logic [PSUM_WIDTH-1:0] out_psum_q, out_psum_d;
    logic                  out_bit_q, out_bit_d;

    logic                  col_ready, accept;
    logic [N-1:0]          match;
    logic [PSUM_WIDTH-1:0] psum, thresh_w;

    assign col_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    assign accept    = bus.col_valid && col_ready;

`ifdef XNOR_CONV_THRESHOLD_EN
    assign thresh_w = bus.thresh;
`else
    assign thresh_w = THRESH_DEF;
`endif

    // Column 0 (oldest) sits in the low bits; the new column lands in the top K*CH bits.
    always_comb begin
        window_d = window_q;
        if (accept) window_d = N'({bus.col_in, window_q} >> (K * CH));
    end

    assign match = ~(window_d ^ weights_q);

    always_comb begin
        psum = '0;
        for (int i = 0; i < N; i++) psum = psum + PSUM_WIDTH'(match[i]);
    end

    always_comb begin
        state_d     = state_q;
        weights_d   = weights_q;
        fill_d      = fill_q;
        beat_d      = beat_q;
        w_done_d    = w_done_q;
        out_valid_d = out_valid_q;
        out_psum_d  = out_psum_q;
        out_bit_d   = out_bit_q;

        if (accept) begin
            if (bus.row_start)          fill_d = FW'(1);
            else if (fill_q != FW'(K))  fill_d = fill_q + FW'(1);
        end
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (accept && fill_d == FW'(K)) begin
            out_valid_d = 1'b1;
            out_psum_d  = psum;
            out_bit_d   = (psum >= thresh_w);
        end

        case (state_q)
            IDLE: begin
                if (bus.w_load_start) begin
                    state_d = LOAD_W;
                    beat_d  = '0;
                end
            end
            LOAD_W: begin
                if (bus.w_valid) begin
                    weights_d[int'(beat_q) * CH +: CH] = bus.w_in;
                    if (beat_q == BW'(K * K - 1)) begin
                        state_d  = RUN;
                        w_done_d = 1'b1;
                        beat_d   = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            RUN: begin
                // A reload wins over a same-cycle column: the window restarts empty.
                if (bus.w_load_start && !out_valid_q) begin
                    state_d     = LOAD_W;
                    w_done_d    = 1'b0;
                    fill_d      = '0;
                    beat_d      = '0;
                    out_valid_d = 1'b0;
                    out_psum_d  = out_psum_q;
                    out_bit_d   = out_bit_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            weights_q   <= '0;
            window_q    <= '0;
            fill_q      <= '0;
            beat_q      <= '0;
            w_done_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_psum_q  <= '0;
            out_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            weights_q   <= weights_d;
            window_q    <= window_d;
            fill_q      <= fill_d;
            beat_q      <= beat_d;
            w_done_q    <= w_done_d;
            out_valid_q <= out_valid_d;
            out_psum_q  <= out_psum_d;
            out_bit_q   <= out_bit_d;
        end
    end

    assign bus.col_ready = col_ready;
    assign bus.w_done    = w_done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_psum  = out_psum_q;
    assign bus.out_bit   = out_bit_q;
endmodule

// File: tb/tb_xnor_conv_pe_array_kxk.sv
// Bench for xnor_conv_pe_array_kxk: directed vector table, hand-written corner sequences,
// and randomized traffic scored against a window/weight reference model.
module tb_xnor_conv_pe_array_kxk;
    localparam int K  = 3;
    localparam int CH = 1;
    localparam int PW = 4;
    localparam int N  = K * K * CH;
`ifdef XNOR_CONV_THRESHOLD_EN
    localparam int THR = 7;
`else
    localparam int THR = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    xnor_conv_pe_array_kxk_if #(.K(K), .CH(CH), .PSUM_WIDTH(PW)) bus ();
    xnor_conv_pe_array_kxk #(.K(K), .CH(CH), .PSUM_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: weight bits by window position, window as a list of columns.
    logic [N-1:0]    mw;
    logic [K*CH-1:0] win [K];
    int              mfill = 0;
    int              expq[$];

    function automatic int model_psum();
        int s = 0;
        for (int c = 0; c < K; c++)
            for (int r = 0; r < K; r++)
                for (int b = 0; b < CH; b++)
                    if (win[c][r*CH+b] == mw[(c*K+r)*CH+b]) s++;
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) chk("sb_spurious", bus.out_valid, 0);
                else begin
                    int e;
                    e = expq.pop_front();
                    chk("sb_psum", bus.out_psum, e);
                    chk("sb_bit", bus.out_bit, e >= THR);
                end
            end
            if (bus.col_valid && bus.col_ready) begin
                for (int c = 0; c < K - 1; c++) win[c] = win[c+1];
                win[K-1] = bus.col_in;
                mfill = bus.row_start ? 1 : (mfill < K ? mfill + 1 : K);
                if (mfill == K) expq.push_back(model_psum());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [N-1:0] wv);
        tick();
        bus.w_load_start = 1'b1;
        tick();
        bus.w_load_start = 1'b0;
        chk("load_w_done_low", bus.w_done, 0);
        for (int j = 0; j < K * K; j++) begin
            bus.w_valid = 1'b1;
            bus.w_in    = wv[j*CH +: CH];
            tick();
            if (j == K * K - 2) chk("load_w_done_early", bus.w_done, 0);
        end
        bus.w_valid = 1'b0;
        chk("load_w_done_set", bus.w_done, 1);
        mw    = wv;
        mfill = 0;
    endtask

    task automatic send_col(input logic [K*CH-1:0] col, input bit rs);
        int n = 0;
        bus.col_valid = 1'b1;
        bus.col_in    = col;
        bus.row_start = rs;
        #1;
        while (!bus.col_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.col_ready) chk("col_ready_timeout", bus.col_ready, 1);
        @(posedge clk);
        #1;
        bus.col_valid = 1'b0;
        bus.row_start = 1'b0;
    endtask

    typedef struct {
        logic [2:0] col;
        bit         rs;
        bit         ev;
        int         ep;
    } vec_t;

    vec_t tv [11];

    initial begin
        tv[0]  = '{3'b111, 1, 0, 0};
        tv[1]  = '{3'b111, 0, 0, 0};
        tv[2]  = '{3'b111, 0, 1, 9};
        tv[3]  = '{3'b000, 0, 1, 6};
        tv[4]  = '{3'b000, 0, 1, 3};
        tv[5]  = '{3'b111, 1, 0, 0};
        tv[6]  = '{3'b111, 1, 0, 0};
        tv[7]  = '{3'b111, 0, 0, 0};
        tv[8]  = '{3'b111, 0, 1, 9};
        tv[9]  = '{3'b101, 0, 1, 8};
        tv[10] = '{3'b010, 0, 1, 6};

        for (int c = 0; c < K; c++) win[c] = '0;
        mw               = '0;
        bus.w_load_start = 1'b0;
        bus.w_valid      = 1'b0;
        bus.w_in         = '0;
        bus.col_valid    = 1'b1;
        bus.col_in       = '0;
        bus.row_start    = 1'b0;
        bus.out_ready    = 1'b1;
`ifdef XNOR_CONV_THRESHOLD_EN
        bus.thresh       = PW'(THR);
`endif

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_psum", bus.out_psum, 0);
        chk("rst_out_bit", bus.out_bit, 0);
        chk("rst_col_ready", bus.col_ready, 0);
        chk("rst_w_done", bus.w_done, 0);
        rst = 1'b1;
        tick();
        chk("idle_col_ready", bus.col_ready, 0);
        bus.col_valid = 1'b0;

        // Directed table with all-ones weights
        load({N{1'b1}});
        foreach (tv[i]) begin
            send_col(tv[i].col, tv[i].rs);
            chk($sformatf("vec%0d_valid", i), bus.out_valid, tv[i].ev);
            if (tv[i].ev) begin
                chk($sformatf("vec%0d_psum", i), bus.out_psum, tv[i].ep);
                chk($sformatf("vec%0d_bit", i), bus.out_bit, tv[i].ep >= THR);
            end
        end

        // Backpressure: result held, columns blocked, then drain+accept in one cycle
        bus.out_ready = 1'b0;
        bus.col_valid = 1'b1;
        bus.col_in    = 3'b000;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_col_ready", bus.col_ready, 0);
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_psum_hold", bus.out_psum, 6);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", bus.col_ready, 1);
        @(posedge clk);
        #1;
        bus.col_valid = 1'b0;
        chk("bp_next_valid", bus.out_valid, 1);
        chk("bp_next_psum", bus.out_psum, 3);
        chk("bp_next_bit", bus.out_bit, 3 >= THR);
        tick();
        chk("bp_drained", bus.out_valid, 0);

        // Weight reload with zeros
        load({N{1'b0}});
        send_col(3'b000, 1);
        send_col(3'b000, 0);
        send_col(3'b000, 0);
        chk("reload_valid", bus.out_valid, 1);
        chk("reload_psum", bus.out_psum, 9);

        // Reset in the middle of a weight load
        tick();
        bus.w_load_start = 1'b1;
        tick();
        bus.w_load_start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bus.w_valid = 1'b1;
            bus.w_in    = 1'b1;
            tick();
        end
        bus.w_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_w_done", bus.w_done, 0);
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_col_ready", bus.col_ready, 0);
        expq.delete();
        mfill = 0;
        tick();
        rst = 1'b1;
        bus.col_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_blocked", bus.col_ready, 0);
        end
        bus.col_valid = 1'b0;

        // Randomized traffic against the model
        load(N'($urandom));
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(3) != 0);
            bus.col_valid = ($urandom_range(9) < 7);
            bus.col_in    = K'($urandom);
            bus.row_start = ($urandom_range(9) == 0);
            tick();
        end
        bus.col_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("sb_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
